// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states, parity modes and baud defaults shared with the transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam int BAUD_DIV_DEFAULT = 104;
  localparam int BAUD_DIV_SIM = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer followed by a registered 3-sample majority filter
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_f
);
  logic [1:0] sync;
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      hist <= '1;
      rx_f <= 1'b1;
    end else begin
      sync <= {sync[0], rx};
      hist <= {hist[0], sync[1]};
      rx_f <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with parity, framing, break and overrun reporting
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  rx_state_t state;
  logic rx_f;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic stop_cnt;
  logic [DATA_BITS-1:0] sh;
  logic pbit, ferr, stop0, fin;
  logic tick, complete, perr_n, brk_n, xfer;
  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rx_f(rx_f)
  );
  always_comb begin
    tick = cnt == LAST;
    complete = state == ST_STOP && fin;
    perr_n = (PARITY != PARITY_NONE) && ((^sh ^ pbit) != (PARITY == PARITY_ODD));
    brk_n = ~|sh & ((PARITY == PARITY_NONE) | ~pbit) & ~stop0;
    xfer = valid & ready;
  end
  // fin marks the cycle after the last stop sample, where the frame completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      sh <= '0;
      pbit <= 1'b0;
      ferr <= 1'b0;
      stop0 <= 1'b0;
      fin <= 1'b0;
    end else begin
      cnt <= (state inside {ST_START, ST_DATA, ST_PAR, ST_STOP}) && !tick ? cnt + 1'b1 : '0;
      case (state)
        ST_IDLE:
          if (!rx_f) begin
            state <= ST_START;
            bit_cnt <= '0;
            stop_cnt <= 1'b0;
            ferr <= 1'b0;
            fin <= 1'b0;
          end
        ST_START:
          if (cnt == HALF) begin
            cnt <= '0;
            state <= rx_f ? ST_IDLE : ST_DATA;
          end
        ST_DATA:
          if (tick) begin
            sh <= {rx_f, sh[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state <= PARITY != PARITY_NONE ? ST_PAR : ST_STOP;
          end
        ST_PAR:
          if (tick) begin
            pbit <= rx_f;
            state <= ST_STOP;
          end
        ST_STOP:
          if (fin) begin
            fin <= 1'b0;
            state <= ferr ? ST_WAIT_HI : ST_IDLE;
          end else if (tick) begin
            if (!rx_f) ferr <= 1'b1;
            if (!stop_cnt) stop0 <= rx_f;
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_cnt == LAST_STOP) fin <= 1'b1;
          end
        ST_WAIT_HI: if (rx_f) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete && (!valid || ready)) begin
        data <= sh;
        parity_err <= perr_n;
        frame_err <= ferr;
        break_det <= brk_n;
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (complete && valid && !ready) overrun <= 1'b1;
      else if (xfer) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param at BAUD_DIV=16, 8 data bits, even parity
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int BD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic ready = 1'b1;
  logic [7:0] data;
  logic valid, parity_err, frame_err, break_det, overrun;
  typedef struct packed {
    logic [7:0] d;
    logic pe, fe, bk, ov;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  uart_rx_param #(
    .BAUD_DIV(BD),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .break_det(break_det),
    .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  // start, 8 data LSB first, even parity (optionally inverted), stop, then idle
  task automatic send(input logic [7:0] d, input logic pflip);
    rx = 1'b0;
    wait_n(BD);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_n(BD);
    end
    rx = (^d) ^ pflip;
    wait_n(BD);
    rx = 1'b1;
    wait_n(BD);
    wait_n(2 * BD);
  endtask
  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%0h expected=none", data);
        end else begin
          e = q.pop_front();
          chk("data", 16'(data), 16'(e.d));
          chk("parity_err", 16'(parity_err), 16'(e.pe));
          chk("frame_err", 16'(frame_err), 16'(e.fe));
          chk("break_det", 16'(break_det), 16'(e.bk));
          chk("overrun", 16'(overrun), 16'(e.ov));
        end
      end
      prev_v = valid;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    wait_n(4);
    rst = 1'b0;
    wait_n(1);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_data", 16'(data), 16'd0);
    chk("rst_flags", 16'({parity_err, frame_err, break_det, overrun}), 16'd0);
    wait_n(2 * BD);
    q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0});
    send(8'hA5, 1'b0);
    q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0});
    send(8'h3C, 1'b1);
    rx = 1'b0;
    wait_n(5);
    rx = 1'b1;
    wait_n(3 * BD);
    chk("false_start_valid", 16'(valid), 16'd0);
    q.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    rx = 1'b0;
    wait_n(20 * BD);
    chk("break_no_second_valid", 16'(valid), 16'd0);
    rx = 1'b1;
    wait_n(4 * BD);
    q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0});
    send(8'hC3, 1'b0);
    ready = 1'b0;
    q.push_back('{8'h11, 1'b0, 1'b0, 1'b0, 1'b0});
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("ovr_valid", 16'(valid), 16'd1);
    chk("ovr_data", 16'(data), 16'h11);
    chk("ovr_flag", 16'(overrun), 16'd1);
    ready = 1'b1;
    wait_n(1);
    ready = 1'b0;
    wait_n(1);
    chk("xfer_valid", 16'(valid), 16'd0);
    chk("xfer_overrun", 16'(overrun), 16'd0);
    chk("xfer_data_held", 16'(data), 16'h11);
    ready = 1'b1;
    wait_n(BD);
    rx = 1'b0;
    wait_n(BD);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h5A >> i;
      wait_n(BD);
    end
    rx = 1'b1;
    wait_n(BD / 2);
    rst = 1'b1;
    wait_n(1);
    chk("midrst_valid", 16'(valid), 16'd0);
    chk("midrst_data", 16'(data), 16'd0);
    chk("midrst_flags", 16'({parity_err, frame_err, break_det, overrun}), 16'd0);
    wait_n(2);
    rst = 1'b0;
    wait_n(3 * BD);
    chk("midrst_no_word", 16'(valid), 16'd0);
    q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});
    send(8'h5A, 1'b0);
    for (int i = 0; i < 20 * BD && q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter: BAUD_DIV, 104, clk cycles per bit period (legal range 8..65535).
REQ-002 Parameter: DATA_BITS, 8, data bits per frame (legal range 5..9).
REQ-003 Parameter: PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter: STOP_BITS, 1, stop bits per frame (1 or 2).
REQ-005 Port: clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 Port: rst, input, 1, reset; synchronous and active-high.
REQ-007 Port: rx, input, 1, asynchronous serial line, idle high, LSB first.
REQ-008 Port: data, output, DATA_BITS, received word; stable while valid=1.
REQ-009 Port: valid, output, 1, data is available.
REQ-010 Port: ready, input, 1, consumer accepts the word; transfer occurs on a cycle with valid=1 and ready=1.
REQ-011 Port: parity_err, output, 1, parity mismatch flag for the held word.
REQ-012 Port: frame_err, output, 1, a stop bit was sampled low for the held word.
REQ-013 Port: break_det, output, 1, held frame was all-zero, including the stop bit.
REQ-014 Port: overrun, output, 1, sticky flag: at least one frame was discarded since the last transfer.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer and then a 3-sample majority filter (rx_f) before use; this adds 3 cycles of latency.
REQ-016 FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-017 IDLE: on rx_f=0, go to START and clear the bit-period counter.
REQ-018 START: at count BAUD_DIV/2 (integer division), if rx_f=1, this is a false start: go to IDLE with no flags raised. Otherwise clear the counter and go to DATA.
REQ-019 DATA: sample rx_f each time the counter reaches BAUD_DIV-1, shifting LSB first. After DATA_BITS samples, go to PAR if PARITY!=0, else go to STOP.
REQ-020 PAR: sample one bit; the error flag = (XOR of data bits XOR sampled bit) != expected value, where expected is 1 for odd parity and 0 for even parity.
REQ-021 STOP: sample STOP_BITS bits; frame error if any sampled stop bit is 0.
REQ-022 Frame completion SHALL occur on the cycle after the last stop-bit sample. If any stop bit was 0, go to WAIT_HI; otherwise go to IDLE.
REQ-023 WAIT_HI: remain until rx_f=1, then go to IDLE. This prevents a break from being re-detected as a new start.
REQ-024 break_det SHALL be set when all data bits, the parity bit (if present) and the first stop bit are 0.
REQ-025 On completion with valid=0, or with valid=1 and ready=1 in the same cycle: load data and the three error flags, and assert valid on the next cycle.
REQ-026 On completion with valid=1 and ready=0: discard the new frame, set overrun, and leave the held data and flags unchanged.
REQ-027 valid SHALL fall the cycle after a transfer unless a reload occurs in the same cycle. overrun SHALL clear on transfer, but stays set if a discard coincides with the transfer.
REQ-028 The bit-period counter SHALL be sized to ceil(log2(BAUD_DIV)) bits, wrap at BAUD_DIV-1, and run only in START, DATA, PAR and STOP.
REQ-029 For DATA_BITS<8, data SHALL occupy the LSBs of the data port. No padding exists; the port width equals DATA_BITS.

Reset
REQ-030 While rst=1 at a clk edge: state=IDLE, counters=0, valid=0, data=0, parity_err=0, frame_err=0, break_det=0, overrun=0, and synchronizer flops=1.
REQ-031 rst asserted mid-frame SHALL abort the frame with no completion. After rst deasserts, reception resumes at the next falling edge of rx_f.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the PARITY_NONE/ODD/EVEN constants, and the default BAUD_DIV values shared with the transmitter.
REQ-033 A sub-module uart_rx_sync SHALL contain the synchronizer and majority filter, so the transmitter loopback bench can reuse it.

Verification
REQ-034 Bench settings: BAUD_DIV=16, DATA_BITS=8, PARITY=2, STOP_BITS=1. Send 0xA5 with correct parity → data=0xA5, valid=1, and all flags 0.
REQ-035 Same settings, send 0x3C with parity bit inverted → data=0x3C and parity_err=1.
REQ-036 Pulse rx low for 5 cycles only → valid stays 0 and the FSM returns to IDLE (false start).
REQ-037 Hold rx low for 20 bit periods → one word with data=0x00, frame_err=1 and break_det=1. No second frame is reported until rx returns high.
REQ-038 Send 0x11 then 0x22 with ready=0 throughout → data=0x11 and overrun=1. Raise ready for one cycle → valid=0 and overrun=0.
REQ-039 Assert rst during bit 4 of a frame → all outputs 0 on the next cycle. A following frame carrying 0x5A is received correctly.
